// File: rtl/inst_decode_if.sv
// Decode-stage bundle: fetch/write-back inputs toward the decoder and the
// registered decoded bundle coming back out.
interface inst_decode_if;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        op_valid;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        alu_src_imm;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        illegal;

    modport master (
        output inst_in, inst_valid, stall, wb_en, wb_addr, wb_data,
        input  op_valid, alu_op, rs_data, rt_data, imm_ext, rd_addr,
        input  reg_we, mem_re, mem_we, alu_src_imm, branch_eq, branch_ne, jump, illegal
    );

    modport slave (
        input  inst_in, inst_valid, stall, wb_en, wb_addr, wb_data,
        output op_valid, alu_op, rs_data, rt_data, imm_ext, rd_addr,
        output reg_we, mem_re, mem_we, alu_src_imm, branch_eq, branch_ne, jump, illegal
    );
endinterface

// File: rtl/inst_decode.sv
// MIPS-32 subset decode stage: 32x32 register file plus a one-cycle registered
// decoded bundle. Define DECODE_BYPASS_EN to forward same-cycle write-back data.
module inst_decode #(
    parameter int REG_NUM = 32
) (
    input  logic         clk,
    input  logic         clr,
    inst_decode_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_LUI = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic op_valid;
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic alu_src_imm;
        logic branch_eq;
        logic branch_ne;
        logic jump;
        logic illegal;
    } ctrl_t;

    logic [31:0] regs [REG_NUM];
    logic [REG_NUM-1:0] wr_sel;

    ctrl_t       ctrl_reg, ctrl_next;
    logic [3:0]  alu_op_reg, alu_op_next;
    logic [31:0] imm_ext_reg, imm_ext_next;
    logic [31:0] rs_data_reg, rs_data_next;
    logic [31:0] rt_data_reg, rt_data_next;
    logic [4:0]  rd_addr_reg, rd_addr_next;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = bus.inst_in[31:26];
    assign rs_idx   = bus.inst_in[25:21];
    assign rt_idx   = bus.inst_in[20:16];
    assign rd_idx   = bus.inst_in[15:11];
    assign shamt    = bus.inst_in[10:6];
    assign funct    = bus.inst_in[5:0];
    assign imm_sext = {{16{bus.inst_in[15]}}, bus.inst_in[15:0]};
    assign imm_zext = {16'b0, bus.inst_in[15:0]};

    // r0 has no write strobe, so it stays at its reset value of zero.
    assign wr_sel[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_wr_sel
            assign wr_sel[gi] = bus.wb_en && (bus.wb_addr == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (wr_sel[i]) regs[i] <= bus.wb_data;
            end
        end
    end

    always_comb begin
        rs_data_next = (rs_idx == 5'd0) ? 32'd0 : regs[rs_idx];
        rt_data_next = (rt_idx == 5'd0) ? 32'd0 : regs[rt_idx];
`ifdef DECODE_BYPASS_EN
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs_idx) rs_data_next = bus.wb_data;
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rt_idx) rt_data_next = bus.wb_data;
`endif
    end

    always_comb begin
        ctrl_next          = '0;
        ctrl_next.op_valid = 1'b1;
        alu_op_next        = ALU_ADD;
        imm_ext_next       = imm_sext;
        rd_addr_next       = rt_idx;
        case (opcode)
            OP_RTYPE: begin
                ctrl_next.reg_we = 1'b1;
                rd_addr_next     = rd_idx;
                imm_ext_next     = {27'b0, shamt};
                case (funct)
                    FN_ADD: alu_op_next = ALU_ADD;
                    FN_SUB: alu_op_next = ALU_SUB;
                    FN_AND: alu_op_next = ALU_AND;
                    FN_OR:  alu_op_next = ALU_OR;
                    FN_XOR: alu_op_next = ALU_XOR;
                    FN_NOR: alu_op_next = ALU_NOR;
                    FN_SLT: alu_op_next = ALU_SLT;
                    FN_SLL: alu_op_next = ALU_SLL;
                    FN_SRL: alu_op_next = ALU_SRL;
                    default: begin
                        ctrl_next.reg_we  = 1'b0;
                        ctrl_next.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_next.reg_we      = 1'b1;
                ctrl_next.alu_src_imm = 1'b1;
                case (opcode)
                    OP_ANDI: begin alu_op_next = ALU_AND; imm_ext_next = imm_zext; end
                    OP_ORI:  begin alu_op_next = ALU_OR;  imm_ext_next = imm_zext; end
                    OP_XORI: begin alu_op_next = ALU_XOR; imm_ext_next = imm_zext; end
                    OP_LUI:  alu_op_next = ALU_LUI;
                    default: alu_op_next = ALU_ADD;
                endcase
            end
            // Loads and stores form their address as rs + imm.
            OP_LW: begin
                ctrl_next.mem_re      = 1'b1;
                ctrl_next.reg_we      = 1'b1;
                ctrl_next.alu_src_imm = 1'b1;
            end
            OP_SW: begin
                ctrl_next.mem_we      = 1'b1;
                ctrl_next.alu_src_imm = 1'b1;
            end
            OP_BEQ: begin
                ctrl_next.branch_eq = 1'b1;
                alu_op_next         = ALU_SUB;
            end
            OP_BNE: begin
                ctrl_next.branch_ne = 1'b1;
                alu_op_next         = ALU_SUB;
            end
            OP_J: begin
                ctrl_next.jump = 1'b1;
                imm_ext_next   = {6'b0, bus.inst_in[25:0]};
            end
            default: ctrl_next.illegal = 1'b1;
        endcase
    end

    // A bubble clears the flags only; the data fields are don't-care and simply hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl_reg    <= '0;
            alu_op_reg  <= '0;
            imm_ext_reg <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            rd_addr_reg <= '0;
        end else if (!bus.stall) begin
            if (bus.inst_valid) begin
                ctrl_reg    <= ctrl_next;
                alu_op_reg  <= alu_op_next;
                imm_ext_reg <= imm_ext_next;
                rs_data_reg <= rs_data_next;
                rt_data_reg <= rt_data_next;
                rd_addr_reg <= rd_addr_next;
            end else begin
                ctrl_reg <= '0;
            end
        end
    end

    assign bus.op_valid    = ctrl_reg.op_valid;
    assign bus.reg_we      = ctrl_reg.reg_we;
    assign bus.mem_re      = ctrl_reg.mem_re;
    assign bus.mem_we      = ctrl_reg.mem_we;
    assign bus.alu_src_imm = ctrl_reg.alu_src_imm;
    assign bus.branch_eq   = ctrl_reg.branch_eq;
    assign bus.branch_ne   = ctrl_reg.branch_ne;
    assign bus.jump        = ctrl_reg.jump;
    assign bus.illegal     = ctrl_reg.illegal;
    assign bus.alu_op      = alu_op_reg;
    assign bus.imm_ext     = imm_ext_reg;
    assign bus.rs_data     = rs_data_reg;
    assign bus.rt_data     = rt_data_reg;
    assign bus.rd_addr     = rd_addr_reg;
endmodule
